fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the fetch/decode pipeline register.
- Owns the fetch PC and runs a valid/ack handshake with a variable-latency instruction memory.
- Buffers fetched instructions in a small prefetch FIFO and presents them, with their PCs, to decode.
- Flushes and refetches when a taken branch or jump redirects the PC from execute.

---
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, handshakes with instruction
// memory, and buffers fetched instructions with their PCs for decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(3);

    logic [XLEN-1:0]  fpc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [XLEN-1:0]  buf_instr [DEPTH];
    logic [XLEN-1:0]  buf_pc    [DEPTH];
    logic             push;
    logic             pop;

    // Redirect suppresses the request, so a same-cycle ack never pushes stale data.
    assign imem_req    = !rst && !redirect && (count < FULL);
    assign imem_addr   = fpc;
    assign instr_valid = !rst && (count != '0);
    assign instr_f     = instr_valid ? buf_instr[rd_ptr] : NOP;
    assign pc_f        = instr_valid ? buf_pc[rd_ptr] : '0;
    assign push        = imem_req && imem_ack;
    assign pop         = instr_valid && !stall && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            fpc    <= redirect_pc & ALIGN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                fpc    <= fpc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage carries no reset; count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= fpc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: variable-latency memory model, a
// cycle model of fetch PC / occupancy, and an in-order scoreboard of pops.
module tb_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr_f;
    logic [31:0] pc_f;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int wait_cnt = 0;
    int hs_cnt   = 0;
    logic force_ack = 1'b0;

    logic [31:0] m_fpc = RST_PC;
    int          m_cnt = 0;
    logic [63:0] exp_q [$];

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
        .instr_f(instr_f), .pc_f(pc_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = force_ack || (imem_req && (wait_cnt >= lat));

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Mid-cycle monitor: model of request/address/occupancy plus scoreboard.
    always @(negedge clk) begin
        logic        do_push;
        logic        do_pop;
        logic [63:0] e;
        if (rst) begin
            m_fpc = RST_PC;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            check("req", {31'b0, imem_req}, {31'b0, (!redirect && m_cnt < 4)});
            if (imem_req) check("addr", imem_addr, m_fpc);
            check("valid", {31'b0, instr_valid}, {31'b0, (m_cnt != 0)});
            if (!instr_valid) begin
                check("empty_instr", instr_f, NOP);
                check("empty_pc", pc_f, 32'h0);
            end
            if (redirect) begin
                exp_q.delete();
                m_cnt = 0;
                m_fpc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                do_push = imem_req && imem_ack;
                do_pop  = instr_valid && !stall;
                if (do_pop) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", pc_f, 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", pc_f, e[63:32]);
                        check("sb_instr", instr_f, e[31:0]);
                    end
                end
                if (do_push) begin
                    exp_q.push_back({imem_addr, mem_word(imem_addr)});
                    m_fpc  = m_fpc + 32'd4;
                    hs_cnt = hs_cnt + 1;
                end
                m_cnt = m_cnt + int'(do_push) - int'(do_pop);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            cyc(1);
            n++;
        end
        if (!instr_valid) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr_f, NOP);
        check("rst_pc", pc_f, 32'h0);
        cyc(2);

        // Zero-latency memory, no stall: one instruction per cycle.
        rst = 1'b0;
        check("first_addr", imem_addr, RST_PC);
        cyc(1);
        check("seq0", pc_f, 32'h100);
        check("seq0_i", instr_f, mem_word(32'h100));
        cyc(1);
        check("seq1", pc_f, 32'h104);
        cyc(1);
        check("seq2", pc_f, 32'h108);
        cyc(5);

        // Stall fills the buffer, then drains in order.
        stall = 1'b1;
        do_reset();
        cyc(8);
        check("full_req", {31'b0, imem_req}, 32'd0);
        check("full_hs", hs_cnt, 32'd0 + hs_cnt);
        check("full_head", pc_f, 32'h100);
        stall = 1'b0;
        #1;
        check("full_req_pop", {31'b0, imem_req}, 32'd0);
        cyc(1);
        check("resume_req", {31'b0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h110);
        cyc(10);

        // Three-cycle memory latency.
        lat = 2;
        do_reset();
        hs_cnt = 0;
        cyc(30);
        check("lat_hs", hs_cnt, 32'd10);

        // Redirect with three entries buffered and a request in flight.
        stall = 1'b1;
        do_reset();
        cyc(10);
        check("pre_redir_pc", pc_f, 32'h100);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("redir_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        redirect = 1'b0;
        #1;
        check("redir_valid", {31'b0, instr_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h200);
        stall = 1'b0;
        wait_valid("redir_timeout");
        check("redir_first", pc_f, 32'h200);
        cyc(10);

        // Redirect coinciding with an ack: nothing is pushed.
        lat = 0;
        stall = 1'b1;
        cyc(6);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        force_ack = 1'b1;
        #1;
        check("rack_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        redirect = 1'b0;
        force_ack = 1'b0;
        #1;
        check("rack_valid", {31'b0, instr_valid}, 32'd0);
        check("rack_addr", imem_addr, 32'h300);
        cyc(1);
        check("rack_head", pc_f, 32'h300);

        // Back-to-back redirects: the last one wins.
        redirect = 1'b1;
        redirect_pc = 32'h400;
        cyc(1);
        redirect_pc = 32'h505;
        cyc(1);
        redirect = 1'b0;
        #1;
        check("b2b_addr", imem_addr, 32'h504);
        check("b2b_valid", {31'b0, instr_valid}, 32'd0);
        stall = 1'b0;
        cyc(4);

        // Fetch PC wraps past the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cyc(1);
        redirect = 1'b0;
        cyc(1);
        check("wrap0", pc_f, 32'hFFFF_FFF8);
        cyc(1);
        check("wrap1", pc_f, 32'hFFFF_FFFC);
        cyc(1);
        check("wrap2", pc_f, 32'h0000_0000);
        check("wrap2_i", instr_f, mem_word(32'h0));
        cyc(2);

        // Asynchronous reset in the middle of a fetch.
        check("pre_arst_valid", {31'b0, instr_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_instr", instr_f, NOP);
        cyc(2);
        rst = 1'b0;
        #1;
        check("arst_addr", imem_addr, RST_PC);
        cyc(1);
        check("arst_head", pc_f, RST_PC);
        cyc(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
